// File: rtl/switch_pkg.sv
// Shared switch definitions: port width, default FIFO depth, transmitter states, FIFO entry layout.
package switch_pkg;
    localparam int PORT_WIDTH    = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    typedef struct packed {
        logic                  eop;
        logic [PORT_WIDTH-1:0] data;
    } fifo_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read; full/empty come from an extra pointer wrap bit.
// Writes while full and reads while empty are dropped inside the FIFO.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/port_transmitter.sv
// Buffers fabric bytes and streams only complete packets to an external reader, zero-bubble across packets.
// in_ready depends only on registered FIFO state; the reader is stalled by holding read low.
module port_transmitter
    import switch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PORT_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_eop,
    output logic                  in_ready,
    output logic [PORT_WIDTH-1:0] port,
    output logic                  ready,
    input  logic                  read,
    output logic                  overflow
);
    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_t   state;
    tx_state_t   state_next;
    fifo_entry_t head;
    fifo_entry_t wr_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        fire;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] pkt_next;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign fire     = ready && read && !fifo_empty;
    assign wr_entry = '{eop: in_eop, data: in_data};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PORT_WIDTH + 1)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (wr_entry),
        .rd_en   (fire),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        pkt_next = pkt_count;
        if (accept && in_eop) pkt_next = pkt_next + CW'(1);
        if (fire && head.eop) pkt_next = pkt_next - CW'(1);
    end

    // Leaving SEND looks at the post-update count so an eop arriving this cycle keeps the stream going.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        port       = '0;
        case (state)
            IDLE: begin
                if (pkt_count != '0) state_next = SEND;
            end
            SEND: begin
                ready = 1'b1;
                port  = head.data;
                if (fire && head.eop && (pkt_next == '0)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pkt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            pkt_count <= pkt_next;
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end
endmodule

// File: doc/port_transmitter.md
PORT_TRANSMITTER -- requirements
Module: port_transmitter

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes, power of two, minimum 4.
REQ-002 SHALL have port clock, input, 1, single clock; all logic on posedge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port in_data, input, 8, byte from switch fabric.
REQ-005 SHALL have port in_valid, input, 1, in_data valid this cycle.
REQ-006 SHALL have port in_eop, input, 1, in_data is the last byte of a packet.
REQ-007 SHALL have port in_ready, output, 1, FIFO can accept a byte (not full).
REQ-008 SHALL have port port, output, 8, byte presented to the external reader.
REQ-009 SHALL have port ready, output, 1, a byte is presented on port.
REQ-010 SHALL have port read, input, 1, external reader consumes the presented byte.
REQ-011 SHALL have port overflow, output, 1, sticky flag for a write attempted while full.

Function
REQ-012 SHALL store each accepted byte together with its eop bit in FIFO order; accept = in_valid && in_ready at posedge.
REQ-013 SHALL drive in_ready = 1 iff FIFO occupancy < DEPTH; no combinational path from read to in_ready.
REQ-014 SHALL ignore writes while in_ready = 0 and set overflow, which holds until reset.
REQ-015 SHALL keep pkt_count (width $clog2(DEPTH)+1) = number of complete packets (eop byte stored) not yet fully read.
REQ-016 SHALL implement FSM IDLE/SEND: IDLE -> SEND when pkt_count > 0; SEND -> IDLE when the eop byte is read and no other complete packet remains (counting an eop written in the same cycle); otherwise stays SEND.
REQ-017 SHALL drive ready = 1 only in SEND, and port = FIFO head byte in SEND, 8'h00 in IDLE.
REQ-018 SHALL transfer one byte at each posedge where ready && read; port shows the next byte from the cycle after (zero-bubble streaming across packet boundaries).
REQ-019 SHALL ignore read while ready = 0 (no pointer movement, no error).
REQ-020 SHALL, on a simultaneous write and read, perform both: occupancy unchanged, pkt_count adjusted by +eop_in -eop_out.
REQ-021 SHALL never present bytes of an incomplete packet: ready remains 0 until that packet's eop byte is stored.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-023 SHALL hold port and ready stable while ready && !read.

Reset
REQ-024 SHALL, on reset assertion, asynchronously set FSM = IDLE, pointers = 0, pkt_count = 0, overflow = 0, ready = 0, port = 8'h00, in_ready = 1.
REQ-025 SHALL discard all buffered data, including a packet mid-transfer, when reset is asserted; the first write after release lands at address 0.
REQ-026 SHALL not require FIFO storage contents to be reset.

Structure
REQ-027 SHALL take PORT_WIDTH = 8, DEFAULT_DEPTH = 16 and the IDLE/SEND state enum from the shared switch package.
REQ-028 SHALL use one sub-module, sync_fifo (9-bit entries: data + eop, DEPTH parameter), with FSM and pkt_count in port_transmitter.

Verification
REQ-029 Write 3-byte packet 8'hA1,8'hA2,8'hA3(eop); read held 1 -> ready rises the cycle after the eop write; port A1,A2,A3 on consecutive cycles; ready = 0, port = 00 after.
REQ-030 Write 8'h10,8'h11 without eop, read = 1 -> ready stays 0; write 8'h12 with eop -> ready = 1, 10,11,12 delivered.
REQ-031 Two back-to-back packets {01,02(eop)},{03(eop)}, read = 1 -> 01,02,03 on consecutive cycles, ready never drops between packets.
REQ-032 DEPTH = 16: write 16 bytes (last eop), then write 8'hFF -> in_ready = 0, FF dropped, overflow = 1; reads return the 16 original bytes; overflow remains 1.
REQ-033 Buffer 4-byte packet, read 2 bytes, assert reset one cycle -> ready = 0, port = 00, in_ready = 1, pkt_count = 0; new packet 8'h55(eop) delivered correctly.
REQ-034 With ready = 1, toggle read 1,0,0,1 over 4 cycles -> exactly 2 bytes consumed, port stable during read = 0 cycles.
